// File: rtl/izh_spike_encoder.sv
`default_nettype none
// izh_spike_encoder: threshold up-crossing spike detector with ISI time-stamps, refractory blocking and event FIFO.
// Optional burst tagging via `define IZH_SPIKE_BURST_EN. Rev 1.0
module izh_spike_encoder #(
  parameter int ISI_W     = 12,
  parameter int DEPTH     = 4,
  parameter int REFRACT   = 3,
  parameter int BURST_ISI = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               v_mem,
  input  logic                     v_valid,
  input  logic [7:0]               thresh,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [ISI_W+1:0]         ev_data,
  output logic [15:0]              spike_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BURST_ISI < 0) begin : g_bad_param
      $error("izh_spike_encoder: DEPTH must be a power of 2 >= 2 and BURST_ISI non-negative");
    end
  endgenerate

  logic [7:0]       r_prev_v;
  logic             r_primed;
  logic             r_first_pend;
  logic [ISI_W-1:0] r_isi_cnt;
  logic [RW-1:0]    r_refr_cnt;
  logic [15:0]      r_spike_cnt;
  logic [ISI_W+1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;

  logic             w_spike;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_burst;
  logic [ISI_W+1:0] w_event;

  assign w_spike = v_valid && r_primed
                && ($signed(r_prev_v) <= $signed(thresh))
                && ($signed(v_mem) > $signed(thresh))
                && (r_refr_cnt == '0);

`ifdef IZH_SPIKE_BURST_EN
  assign w_burst = !r_first_pend && (r_isi_cnt < ISI_W'(BURST_ISI));
`else
  assign w_burst = 1'b0;
`endif

  assign w_event = {w_burst, r_first_pend, r_isi_cnt};
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = (r_level != '0) && ev_ready;
  // A full FIFO still accepts a spike when the head leaves on the same edge.
  assign w_push  = w_spike && (!w_full || w_pop);
  assign w_drop  = w_spike && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_v     <= '0;
      r_primed     <= 1'b0;
      r_first_pend <= 1'b1;
      r_isi_cnt    <= '0;
      r_refr_cnt   <= '0;
      r_spike_cnt  <= '0;
    end else if (v_valid) begin
      r_prev_v <= v_mem;
      if (!r_primed) begin
        r_primed <= 1'b1;
      end else if (w_spike) begin
        r_isi_cnt    <= '0;
        r_first_pend <= 1'b0;
        r_refr_cnt   <= RW'(REFRACT);
        if (r_spike_cnt != 16'hFFFF) begin
          r_spike_cnt <= r_spike_cnt + 16'd1;
        end
      end else begin
        if (r_isi_cnt != '1) begin
          r_isi_cnt <= r_isi_cnt + 1'b1;
        end
        if (r_refr_cnt != '0) begin
          r_refr_cnt <= r_refr_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_event;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign ev_valid   = (r_level != '0);
  assign ev_data    = r_mem[r_rd_ptr];
  assign spike_cnt  = r_spike_cnt;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/izh_spike_encoder.md
# izh_spike_encoder

Downstream stage of the Izhikevich neuron core. It samples the 8-bit signed membrane-voltage output on each update strobe and detects threshold up-crossings as spikes. It time-stamps each spike with its inter-spike interval (ISI), measured in update samples, and queues the resulting events in a small FIFO drained through a valid/ready port. It also keeps a saturating spike count and a sticky overflow flag.

## Interface
Parameters:
- ISI_W, 12, ISI counter and event ISI field width.
- DEPTH, 4, event FIFO depth; must be a power of 2 and ≥ 2.
- REFRACT, 3, number of valid samples after a spike during which detection is blocked; 0 disables refractory blocking.
- BURST_ISI, 8, ISI below which an event is tagged as burst; used only with IZH_SPIKE_BURST_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- v_mem  in  8  signed membrane voltage, i.e. the neuron's v1[17:10].
- v_valid  in  1  sample strobe, high for one cycle per neuron update.
- thresh  in  8  signed spike threshold, compared every valid sample.
- ev_valid  out  1  FIFO holds at least one event.
- ev_ready  in  1  consumer accepts the head event.
- ev_data  out  ISI_W+2  event word {burst, first, isi[ISI_W-1:0]}; shows the head entry.
- spike_cnt  out  16  total detected spikes; saturates at 0xFFFF.
- fifo_level  out  $clog2(DEPTH)+1  number of queued events.
- overflow  out  1  sticky; set when a spike is dropped because the FIFO is full.

## Operation
- State: prev_v (8), primed (1), first_pend (1), isi_cnt (ISI_W), refr_cnt, spike_cnt, FIFO storage, rd/wr pointers, level, overflow.
- Reset values:
  - All outputs 0, so ev_valid=0, ev_data=0, spike_cnt=0, fifo_level=0, overflow=0.
  - Internal state: primed=0, first_pend=1, isi_cnt=0, refr_cnt=0.
- Only cycles with v_valid=1 change prev_v, isi_cnt, refr_cnt and detection state. Other cycles hold them.
- Spike condition on a valid sample: primed && signed(prev_v) ≤ signed(thresh) && signed(v_mem) > signed(thresh) && refr_cnt==0.
- On the first valid sample after reset, prev_v←v_mem and primed←1. No detection takes place on that sample.
- On a spike sample:
  - Form the event word: isi = isi_cnt (saturated value), first = first_pend, burst per Configuration.
  - Then set isi_cnt←0, first_pend←0, refr_cnt←REFRACT, and spike_cnt←spike_cnt+1 (saturating).
- On a non-spike valid sample: isi_cnt increments and saturates at 2^ISI_W−1. refr_cnt decrements if it is nonzero.
- The ISI counts samples strictly between spikes. Spikes on consecutive samples are impossible, because the crossing condition requires prev_v ≤ thresh.
- FIFO:
  - Push on a spike when not full.
  - Pop when ev_valid && ev_ready.
  - When full with a simultaneous push and pop, both happen and the level is unchanged.
  - When full with a push and no pop, the event is dropped and overflow←1. spike_cnt still increments.
  - Empty with ev_ready=1: no effect.
- Pointers wrap modulo DEPTH.
- A change of thresh takes effect on the next valid sample. It never retroactively creates a spike.

## Timing
- Detection is combinational on the sample cycle. The event is written at that rising edge.
- ev_valid is high in the next cycle, so spike-to-event latency is 1 cycle. spike_cnt updates at the same edge.
- ev_data is registered FIFO output. It is stable while ev_valid && !ev_ready, and it advances one edge after an accepted pop.
- Throughput is one pop per cycle. The consumer may hold ev_ready high continuously.
- Asserting rst mid-operation clears the FIFO (queued events are lost), the counters and overflow immediately, without waiting for a clock. After release, the first valid sample primes only.

## Configuration
- IZH_SPIKE_BURST_EN defined: burst bit = (!first && isi < BURST_ISI).
- IZH_SPIKE_BURST_EN undefined: burst bit is constant 0, and the BURST_ISI comparator is absent.

## Test plan
- Reset then prime: v_mem=−60 (first sample), then 25 with thresh=19 → no event on the first sample. The second sample produces an event {0,1,0}, ev_valid high one cycle later, spike_cnt=1.
- ISI measurement: spikes with 5 sub-threshold samples between them, ev_ready=1 → second event isi=5, first=0. With the burst macro enabled and BURST_ISI=8, burst=1. With it disabled, burst=0.
- Refractory, with REFRACT=3: re-crossing 2 samples after a spike → no event. Re-crossing after 4 samples → event with isi=4.
- Backpressure: ev_ready=0 and 5 spikes with DEPTH=4 → fifo_level=4, overflow=1, spike_cnt=5. Draining then yields the 4 oldest events in order, and overflow remains 1.
- Full simultaneous push and pop: with FIFO full, a spike arrives while ev_ready=1 → level stays 4, no overflow, and the new event appears last.
- Async reset mid-stream: rst pulsed between clock edges with 3 queued events → ev_valid=0, fifo_level=0, spike_cnt=0 immediately. The next valid sample does not produce a spike.
